iencode_loader: RTL and testbench
=================================

// Module: iencode_loader
// PURPOSE
//  Instruction encoder and program loader; the inverse of the instruction decoder.
//  - Accepts decoded fields (ctrl, rd, rs, rt, shift, imm) over a valid/ready handshake.
//  - Packs them into the 32-bit RISC instruction word and buffers them in a FIFO.
//  - Writes the words to consecutive instruction-memory addresses, one mem_ack handshake per word.
//  - Used by benches and the boot path to build programs that the decoder executes.
// PARAMETERS
//  DEPTH   4   FIFO entries (power of 2, >=2); includes the word currently being written
//  ADDR_W  10  instruction-memory word-address width
//  BASE    0   first write address (0 <= BASE < 2**ADDR_W)
// PORTS
//  clk        in   1       clock; all state changes on posedge
//  rst        in   1       asynchronous, active-high reset
//  in_valid   in   1       field set on the inputs is valid
//  in_ready   out  1       block accepts the field set this cycle
//  ctrl       in   12      {OPC[11:6], FUNC[5:0]}; FUNC is used only when OPC==0
//  rd         in   5       destination register field
//  rs         in   5       source register field
//  rt         in   5       operand register field (R-type only)
//  shift      in   5       shift amount (R-type only)
//  imm        in   32      sign-extended immediate (OPC!=0 only)
//  mem_we     out  1       memory write request
//  mem_addr   out  ADDR_W  write word address
//  mem_wdata  out  32      encoded instruction word
//  mem_ack    in   1       memory accepted the write this cycle
//  count      out  ADDR_W+1 number of words written since reset
//  done       out  1       last address written; loader is stopped
//  imm_err    out  1       sticky: an imm value could not be represented in 16 bits
// BEHAVIOUR
//  Reset: in_ready=1, mem_we=0, mem_addr=BASE, mem_wdata=0, count=0, done=0, imm_err=0.
//   The FIFO is emptied and the FSM enters IDLE. Reset is asynchronous and also takes
//   effect mid-write: mem_we drops immediately and buffered words are discarded.
//  Encoding (at accept, i.e. in_valid && in_ready):
//   OPC==0: word = {6'd0, rd, rs, rt, shift, FUNC}
//   OPC!=0: word = {OPC, rd, rs, imm[15:0]}; rt, shift and FUNC are ignored.
//   imm_err is set to 1 if OPC!=0 and imm[31:15] is neither all-0 nor all-1.
//   It stays 1 until reset; the truncated word is still written.
//  in_ready = !fifo_full && !done.
//   It depends only on registered state, so a pop in the same cycle does not free a
//   slot for a push when the FIFO is full.
//  Write FSM:
//   IDLE:  FIFO non-empty -> WRITE. Next edge: mem_we=1, mem_wdata=head, mem_addr=ptr.
//   WRITE: hold mem_we, mem_addr and mem_wdata stable until mem_ack=1.
//     On the ack edge: pop the head, count+=1.
//     If ptr == 2**ADDR_W-1 -> DONE: mem_we=0, done=1.
//     Else ptr+=1. If another entry remains, stay in WRITE and present it on the next
//     cycle (1 word/cycle with ack held high). Otherwise go to IDLE with mem_we=0.
//   DONE:  terminal until reset. in_ready=0, mem_we=0; the address never wraps.
//   mem_ack while mem_we=0 is ignored.
//  Latency: a word accepted at edge N with the FIFO empty and the FSM in IDLE drives
//   mem_we=1 from edge N+1.
//  Simultaneous push and pop (not full): both happen; occupancy is unchanged.
// TESTING
//  1. ctrl=12'h020, rd=3, rs=1, rt=2, shift=0, ack=1
//     -> mem_wdata=32'h00611020 at addr 0; count=1; imm_err=0.
//  2. ctrl={6'h08,6'h3F}, rd=4, rs=5, imm=32'hFFFF_FFF0
//     -> mem_wdata=32'h2085FFF0; imm_err=0.
//  3. OPC=6'h08, rd=4, rs=5, imm=32'h0001_0000
//     -> mem_wdata=32'h20850000; imm_err=1, still 1 after later valid immediates.
//  4. mem_ack=0, present 5 words back-to-back
//     -> 4 accepted, in_ready=0 on the 5th. Then ack=1 for 4 cycles
//     -> addrs 0,1,2,3 written in order on consecutive cycles.
//  5. ADDR_W=3, BASE=6, push 3 words, ack=1
//     -> writes at 6 and 7; done=1, count=2; the 3rd word is never written; in_ready=0.
//  6. rst=1 while mem_we=1 with 2 words buffered
//     -> mem_we=0 without waiting for a clock edge; after release count=0, mem_addr=BASE,
//        and the next accepted word is written at BASE.

Source files
------------

// File: rtl/iencode_loader.sv
// iencode_loader: packs decoded instruction fields into 32-bit words,
// buffers them in a FIFO and writes them to consecutive memory addresses.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     field-set handshake (ctrl, rd, rs, rt, shift, imm)
//   mem_we/mem_addr/      memory write request, word address and data;
//   mem_wdata/mem_ack       the request is held until mem_ack
//   count                 words written since reset
//   done                  last address written, loader stopped
//   imm_err               sticky: an immediate did not fit in 16 bits
module iencode_loader #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [11:0]       ctrl,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        shift,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              imm_err
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              imm_err_q, imm_err_d;

  logic [31:0]       fifo_q [DEPTH];
  logic [PW:0]       wr_ptr_q, wr_ptr_d;
  logic [PW:0]       rd_ptr_q, rd_ptr_d;
  logic [PW:0]       occ;
  logic              full, empty;

  logic [5:0]        opc, func;
  logic [31:0]       word;
  logic              imm_bad;
  logic              push, pop, more;

  assign opc  = ctrl[11:6];
  assign func = ctrl[5:0];

  // R-type when OPC is zero, otherwise I-type with truncated immediate
  always_comb begin
    word = '0;
    if (opc == 6'd0) begin
      word = {6'd0, rd, rs, rt, shift, func};
    end else begin
      word = {opc, rd, rs, imm[15:0]};
    end
  end

  // imm[31:15] must be a pure sign extension to fit 16 bits
  assign imm_bad = (opc != 6'd0) &&
                   !((&imm[31:15]) || !(|imm[31:15]));

  assign occ   = wr_ptr_q - rd_ptr_q;
  assign full  = (occ == (PW+1)'(DEPTH));
  assign empty = (occ == '0);

  assign push = in_valid && in_ready;
  assign pop  = (state_q == S_WRITE) && mem_ack;

  // an entry remains after the pop, counting a same-cycle push
  assign more = (occ > (PW+1)'(1)) || push;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    imm_err_d = imm_err_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + (PW+1)'(1);
      if (imm_bad) imm_err_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[PW-1:0]] <= word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      imm_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      imm_err_q <= imm_err_d;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= ADDR_W'(BASE);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (mem_ack) begin
          count_d = count_q + (ADDR_W+1)'(1);
          // top address: stop rather than wrap
          if (&ptr_q) begin
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = more ? S_WRITE : S_IDLE;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // outputs; in_ready uses registered state only
  always_comb begin
    in_ready  = !full && (state_q != S_DONE);
    mem_we    = (state_q == S_WRITE);
    mem_wdata = '0;
    if (state_q == S_WRITE) begin
      mem_wdata = fifo_q[rd_ptr_q[PW-1:0]];
    end
    mem_addr  = ptr_q;
    count     = count_q;
    done      = (state_q == S_DONE);
    imm_err   = imm_err_q;
  end

endmodule

// File: tb/tb_iencode_loader.sv
// tb_iencode_loader: directed checks of iencode_loader, default instance
// plus a small-address instance for the stop-at-top behaviour.
module tb_iencode_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // default instance: ADDR_W=10, BASE=0
  logic        rst, in_valid, in_ready, mem_ack;
  logic [11:0] ctrl;
  logic [4:0]  rd, rs, rt, shift;
  logic [31:0] imm, mem_wdata;
  logic        mem_we, done, imm_err;
  logic [9:0]  mem_addr;
  logic [10:0] count;

  // small instance: ADDR_W=3, BASE=6
  logic        rst1, in_valid1, in_ready1, mem_ack1;
  logic [11:0] ctrl1;
  logic [4:0]  rd1, rs1, rt1, shift1;
  logic [31:0] imm1, mem_wdata1;
  logic        mem_we1, done1, imm_err1;
  logic [2:0]  mem_addr1;
  logic [3:0]  count1;

  int n_cmp = 0;
  int n_err = 0;

  iencode_loader u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl(ctrl), .rd(rd), .rs(rs), .rt(rt), .shift(shift), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .count(count), .done(done), .imm_err(imm_err)
  );

  iencode_loader #(.DEPTH(4), .ADDR_W(3), .BASE(6)) u1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
    .ctrl(ctrl1), .rd(rd1), .rs(rs1), .rt(rt1), .shift(shift1),
    .imm(imm1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_ack(mem_ack1), .count(count1),
    .done(done1), .imm_err(imm_err1)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  // drive one field set for exactly one edge
  task automatic send(input logic [11:0] c, input logic [4:0] d,
                      input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] sh, input logic [31:0] im);
    ctrl = c; rd = d; rs = s; rt = t; shift = sh; imm = im;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mem_ack = 1'b0;
    ctrl = '0; rd = '0; rs = '0; rt = '0; shift = '0; imm = '0;
    rst1 = 1'b1; in_valid1 = 1'b0; mem_ack1 = 1'b0;
    ctrl1 = '0; rd1 = '0; rs1 = '0; rt1 = '0; shift1 = '0; imm1 = '0;
    #12;

    // reset state
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_imm_err", 64'(imm_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // 1: R-type encode, one-cycle latency to mem_we
    mem_ack = 1'b1;
    send(12'h020, 5'd3, 5'd1, 5'd2, 5'd0, 32'h0);
    chk("t1_we_lat0", 64'(mem_we), 64'd0);
    tick();
    chk("t1_we", 64'(mem_we), 64'd1);
    chk("t1_addr", 64'(mem_addr), 64'd0);
    chk("t1_wdata", 64'(mem_wdata), 64'h00611020);
    tick();
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_we_off", 64'(mem_we), 64'd0);
    chk("t1_imm_err", 64'(imm_err), 64'd0);

    // 2: I-type with negative immediate, FUNC ignored
    send(12'h23F, 5'd4, 5'd5, 5'd7, 5'd9, 32'hFFFF_FFF0);
    tick();
    chk("t2_addr", 64'(mem_addr), 64'd1);
    chk("t2_wdata", 64'(mem_wdata), 64'h2085FFF0);
    chk("t2_imm_err", 64'(imm_err), 64'd0);
    tick();

    // 3: out-of-range immediate, sticky error
    send(12'h200, 5'd4, 5'd5, 5'd0, 5'd0, 32'h0001_0000);
    chk("t3_imm_err", 64'(imm_err), 64'd1);
    tick();
    chk("t3_wdata", 64'(mem_wdata), 64'h20850000);
    chk("t3_addr", 64'(mem_addr), 64'd2);
    tick();
    send(12'h200, 5'd4, 5'd5, 5'd0, 5'd0, 32'h0000_7FFF);
    tick();
    chk("t3_wdata2", 64'(mem_wdata), 64'h20857FFF);
    chk("t3_sticky", 64'(imm_err), 64'd1);
    tick();
    chk("t3_count", 64'(count), 64'd4);

    // 4: fill FIFO with ack low, then drain one per cycle
    do_reset();
    chk("t4_rst_imm_err", 64'(imm_err), 64'd0);
    mem_ack = 1'b0;
    ctrl = 12'h020; rs = '0; rt = '0; shift = '0; imm = '0;
    for (int i = 0; i < 5; i++) begin
      rd = 5'(i);
      in_valid = 1'b1;
      chk($sformatf("t4_ready%0d", i), 64'(in_ready),
          (i < 4) ? 64'd1 : 64'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("t4_hold_addr", 64'(mem_addr), 64'd0);
    mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_we%0d", k), 64'(mem_we), 64'd1);
      chk($sformatf("t4_addr%0d", k), 64'(mem_addr), 64'(k));
      chk($sformatf("t4_wdata%0d", k), 64'(mem_wdata),
          64'((32'(k) << 21) | 32'h20));
      tick();
    end
    chk("t4_we_off", 64'(mem_we), 64'd0);
    chk("t4_count", 64'(count), 64'd4);

    // 6: asynchronous reset mid-write with two words buffered
    mem_ack = 1'b0;
    send(12'h020, 5'd1, 5'd0, 5'd0, 5'd0, 32'h0);
    send(12'h020, 5'd2, 5'd0, 5'd0, 5'd0, 32'h0);
    chk("t6_we_pre", 64'(mem_we), 64'd1);
    chk("t6_addr_pre", 64'(mem_addr), 64'd4);
    rst = 1'b1;
    #1;
    chk("t6_we_async", 64'(mem_we), 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_addr", 64'(mem_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_ready", 64'(in_ready), 64'd1);
    chk("t6_empty", 64'(mem_we), 64'd0);
    mem_ack = 1'b1;
    send(12'h020, 5'd9, 5'd8, 5'd7, 5'd6, 32'h0);
    tick();
    chk("t6_new_addr", 64'(mem_addr), 64'd0);
    chk("t6_new_wdata", 64'(mem_wdata), 64'h012839A0);
    tick();
    chk("t6_new_count", 64'(count), 64'd1);

    // 5: small address space stops at the top address
    @(negedge clk);
    rst1 = 1'b0;
    #1;
    chk("t5_rst_addr", 64'(mem_addr1), 64'd6);
    mem_ack1 = 1'b1;
    ctrl1 = 12'h200; rd1 = 5'd1; rs1 = 5'd2;
    in_valid1 = 1'b1;
    imm1 = 32'h11;
    tick();
    chk("t5_we0", 64'(mem_we1), 64'd0);
    imm1 = 32'h22;
    tick();
    chk("t5_we1", 64'(mem_we1), 64'd1);
    chk("t5_addr6", 64'(mem_addr1), 64'd6);
    chk("t5_wdata6", 64'(mem_wdata1), 64'h20220011);
    chk("t5_ready3", 64'(in_ready1), 64'd1);
    imm1 = 32'h33;
    tick();
    in_valid1 = 1'b0;
    chk("t5_addr7", 64'(mem_addr1), 64'd7);
    chk("t5_wdata7", 64'(mem_wdata1), 64'h20220022);
    chk("t5_count1", 64'(count1), 64'd1);
    tick();
    chk("t5_done", 64'(done1), 64'd1);
    chk("t5_we_off", 64'(mem_we1), 64'd0);
    chk("t5_count2", 64'(count1), 64'd2);
    chk("t5_ready0", 64'(in_ready1), 64'd0);
    tick();
    tick();
    chk("t5_stay_we", 64'(mem_we1), 64'd0);
    chk("t5_stay_addr", 64'(mem_addr1), 64'd7);
    chk("t5_stay_count", 64'(count1), 64'd2);
    chk("t5_imm_err", 64'(imm_err1), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
